// File: rtl/program_loader_pkg.sv
// ============================================================================
// program_loader_pkg : shared types and constants for the program loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package program_loader_pkg;

    localparam int INSTR_W = 8;
    localparam int PC_W    = 8;

    localparam logic [INSTR_W-1:0] c_FILL_INSTR_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/program_loader_instr_ram.sv
// ============================================================================
// instr_ram : DEPTH x 8 program store, synchronous write, asynchronous read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_ram
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [INSTR_W-1:0] r_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            r_mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// program_loader : runtime-loaded zero-latency instruction store with core reset.
// Optional macro LOAD_CHECKSUM_EN enables the running load checksum.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter int                 ADDR_W     = 8,
    parameter logic [INSTR_W-1:0] FILL_INSTR = c_FILL_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               cpu_rst,
    output logic               load_done,
    output logic [ADDR_W:0]    prog_len,
    output logic [7:0]         load_checksum
);

    localparam int              DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] c_ONE  = (ADDR_W+1)'(1);

    state_e             r_state_q, w_state_d;
    logic [ADDR_W:0]    r_wr_q,    w_wr_d;
    logic [ADDR_W:0]    r_len_q,   w_len_d;
    logic               r_done_q,  w_done_d;
    logic               w_accept;
    logic               w_in_range;
    logic [INSTR_W-1:0] w_rdata;

    assign load_ready = (r_state_q == LOAD) && !load_start;
    assign w_accept   = load_valid && load_ready;
    assign cpu_rst    = (r_state_q != RUN);
    assign load_done  = r_done_q;
    assign prog_len   = r_len_q;

    always_comb begin
        w_state_d = r_state_q;
        w_wr_d    = r_wr_q;
        w_len_d   = r_len_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (load_start) begin
                    w_state_d = LOAD;
                    w_wr_d    = '0;
                    w_len_d   = '0;
                end else if (run_req) begin
                    w_state_d = RUN;
                end
            end
            LOAD: begin
                if (load_start) begin
                    w_wr_d  = '0;
                    w_len_d = '0;
                end else if (w_accept) begin
                    w_wr_d  = r_wr_q + c_ONE;
                    w_len_d = r_wr_q + c_ONE;
                    // The last slot ends the load even without load_last: no wrap.
                    if (load_last || (r_wr_q == c_LAST)) begin
                        w_state_d = RUN;
                        w_done_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    w_state_d = LOAD;
                    w_wr_d    = '0;
                    w_len_d   = '0;
                end else if (halt_req) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state_q <= IDLE;
            r_wr_q    <= '0;
            r_len_q   <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_wr_q    <= w_wr_d;
            r_len_q   <= w_len_d;
            r_done_q  <= w_done_d;
        end
    end

    instr_ram #(
        .ADDR_W (ADDR_W)
    ) u_instr_ram (
        .clk     (clk),
        .we_i    (w_accept),
        .waddr_i (r_wr_q[ADDR_W-1:0]),
        .wdata_i (load_data),
        .raddr_i (pc[ADDR_W-1:0]),
        .rdata_o (w_rdata)
    );

    // Full-width compare so PC bits above ADDR_W count as out of range.
    assign w_in_range  = ({1'b0, pc} < (PC_W+1)'(r_len_q));
    assign instruction = ((r_state_q == RUN) && w_in_range) ? w_rdata : FILL_INSTR;

`ifdef LOAD_CHECKSUM_EN
    logic [7:0] r_sum_q;

    always_ff @(posedge clk) begin
        if (RST || load_start) begin
            r_sum_q <= 8'h00;
        end else if (w_accept) begin
            r_sum_q <= r_sum_q + load_data;
        end
    end

    assign load_checksum = r_sum_q;
`else
    assign load_checksum = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// tb_program_loader : scoreboard bench driving a default-size and a 4-word loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    logic       clk = 1'b0;
    logic       RST;
    logic       load_start, load_valid, load_last, run_req, halt_req;
    logic [7:0] load_data, pc;

    logic       ready_a, ready_b, crst_a, crst_b, done_a, done_b;
    logic [7:0] instr_a, instr_b, sum_a, sum_b;
    logic [8:0] len_a;
    logic [2:0] len_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q_exp_a[$];
    logic [7:0] q_exp_b[$];

    always #5 clk = ~clk;

    program_loader u_dut_a (
        .clk(clk), .RST(RST), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(ready_a),
        .run_req(run_req), .halt_req(halt_req), .pc(pc), .instruction(instr_a),
        .cpu_rst(crst_a), .load_done(done_a), .prog_len(len_a), .load_checksum(sum_a)
    );

    program_loader #(.ADDR_W(2)) u_dut_b (
        .clk(clk), .RST(RST), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(ready_b),
        .run_req(run_req), .halt_req(halt_req), .pc(pc), .instruction(instr_b),
        .cpu_rst(crst_b), .load_done(done_b), .prog_len(len_b), .load_checksum(sum_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected instructions are queued as pc is driven, then retired after settling.
    task automatic rd(input logic [7:0] addr, input logic [7:0] ea, input logic [7:0] eb);
        pc = addr;
        q_exp_a.push_back(ea);
        q_exp_b.push_back(eb);
        #1;
        chk($sformatf("instr_a pc=%0h", addr), {24'h0, instr_a}, {24'h0, q_exp_a.pop_front()});
        chk($sformatf("instr_b pc=%0h", addr), {24'h0, instr_b}, {24'h0, q_exp_b.pop_front()});
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic exp_ra, input logic exp_rb);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        #1;
        chk("ready_a", {31'h0, ready_a}, {31'h0, exp_ra});
        chk("ready_b", {31'h0, ready_b}, {31'h0, exp_rb});
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    logic [7:0] exp_sum4, exp_sum5a, exp_sum5b;
    logic [7:0] prog4 [4];
    logic [7:0] prog5 [5];

    initial begin
        prog4 = '{8'h41, 8'h86, 8'hC3, 8'h12};
        prog5 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
`ifdef LOAD_CHECKSUM_EN
        exp_sum4  = 8'h9C;
        exp_sum5a = 8'hF0;
        exp_sum5b = 8'hA0;
`else
        exp_sum4  = 8'h00;
        exp_sum5a = 8'h00;
        exp_sum5b = 8'h00;
`endif
        RST = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        run_req = 1'b0; halt_req = 1'b0; load_data = 8'h00; pc = 8'h05;
        step(); step();

        // Reset / idle
        chk("rst cpu_rst_a", {31'h0, crst_a}, 32'h1);
        chk("rst cpu_rst_b", {31'h0, crst_b}, 32'h1);
        chk("rst ready_a", {31'h0, ready_a}, 32'h0);
        chk("rst len_a", {23'h0, len_a}, 32'h0);
        chk("rst len_b", {29'h0, len_b}, 32'h0);
        chk("rst sum_a", {24'h0, sum_a}, 32'h0);
        rd(8'h05, 8'h00, 8'h00);
        RST = 1'b0;
        step();

        // 4-byte load with a 3-cycle valid gap between beats 2 and 3
        pulse_start();
        beat(prog4[0], 1'b0, 1'b1, 1'b1);
        beat(prog4[1], 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("gap len_a", {23'h0, len_a}, 32'h2);
        chk("gap len_b", {29'h0, len_b}, 32'h2);
        beat(prog4[2], 1'b0, 1'b1, 1'b1);
        beat(prog4[3], 1'b1, 1'b1, 1'b1);
        chk("done_a", {31'h0, done_a}, 32'h1);
        chk("done_b", {31'h0, done_b}, 32'h1);
        chk("run cpu_rst_a", {31'h0, crst_a}, 32'h0);
        chk("run cpu_rst_b", {31'h0, crst_b}, 32'h0);
        chk("len4_a", {23'h0, len_a}, 32'h4);
        chk("len4_b", {29'h0, len_b}, 32'h4);
        chk("sum4_a", {24'h0, sum_a}, {24'h0, exp_sum4});
        chk("sum4_b", {24'h0, sum_b}, {24'h0, exp_sum4});
        for (int i = 0; i < 4; i++) rd(8'(i), prog4[i], prog4[i]);
        rd(8'h04, 8'h00, 8'h00);
        rd(8'h44, 8'h00, 8'h00);
        step();
        chk("done_a drop", {31'h0, done_a}, 32'h0);
        chk("done_b drop", {31'h0, done_b}, 32'h0);

        // Halt then resume the stored program
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("halt cpu_rst_a", {31'h0, crst_a}, 32'h1);
        rd(8'h00, 8'h00, 8'h00);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        chk("resume cpu_rst_a", {31'h0, crst_a}, 32'h0);
        rd(8'h02, 8'hC3, 8'hC3);

        // load_start from RUN with a beat in the same cycle
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'h77;
        #1;
        chk("start ready_a", {31'h0, ready_a}, 32'h0);
        step();
        load_start = 1'b0; load_valid = 1'b0;
        chk("restart cpu_rst_a", {31'h0, crst_a}, 32'h1);
        chk("restart len_a", {23'h0, len_a}, 32'h0);
        chk("restart len_b", {29'h0, len_b}, 32'h0);
        rd(8'h00, 8'h00, 8'h00);

        // 5 beats, last on the 5th: the 4-word loader ends on its 4th beat
        for (int i = 0; i < 5; i++) begin
            beat(prog5[i], (i == 4), 1'b1, (i < 4));
            chk($sformatf("done_b beat%0d", i), {31'h0, done_b}, {31'h0, (i == 3)});
        end
        chk("done_a 5", {31'h0, done_a}, 32'h1);
        chk("len5_a", {23'h0, len_a}, 32'h5);
        chk("len5_b", {29'h0, len_b}, 32'h4);
        chk("ready_b full", {31'h0, ready_b}, 32'h0);
        chk("sum5_a", {24'h0, sum_a}, {24'h0, exp_sum5a});
        chk("sum5_b", {24'h0, sum_b}, {24'h0, exp_sum5b});
        for (int i = 0; i < 4; i++) rd(8'(i), prog5[i], prog5[i]);
        rd(8'h04, 8'h50, 8'h00);
        rd(8'h05, 8'h00, 8'h00);

        // Reset in the middle of a load
        pulse_start();
        beat(8'h99, 1'b0, 1'b1, 1'b1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("midrst cpu_rst_a", {31'h0, crst_a}, 32'h1);
        chk("midrst ready_a", {31'h0, ready_a}, 32'h0);
        chk("midrst len_a", {23'h0, len_a}, 32'h0);
        chk("midrst sum_a", {24'h0, sum_a}, 32'h0);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        chk("empty run cpu_rst_a", {31'h0, crst_a}, 32'h0);
        rd(8'h00, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Instruction-supply end of the core's fetch interface: takes the core's 8-bit PC and returns the 8-bit instruction with zero latency, matching the single-cycle datapath.
- Program storage is filled at runtime through a byte-wide valid/ready load port.
- Drives a core-reset output that holds the core in reset while no valid program is running.
- Sits beside the microprocessor top; core PCOutput feeds pc, instruction feeds the core.

Parameters:
- ADDR_W, 8: program address width; DEPTH = 2**ADDR_W words; legal range 1..8.
- FILL_INSTR, 8'h00: instruction returned for unloaded or out-of-range addresses and whenever not in RUN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- RST  input  1  reset, synchronous, active-high.
- load_start  input  1  pulse: begin a new program load at address 0.
- load_valid  input  1  load_data/load_last valid.
- load_data  input  8  program byte.
- load_last  input  1  final byte of program; sampled only on an accepted beat.
- load_ready  output  1  loader accepts a beat this cycle.
- run_req  input  1  pulse: run the currently stored program.
- halt_req  input  1  pulse: stop the core.
- pc  input  8  core program counter.
- instruction  output  8  instruction for pc; combinational.
- cpu_rst  output  1  reset to core, active-high.
- load_done  output  1  one-cycle pulse, load completed.
- prog_len  output  ADDR_W+1  number of stored bytes.
- load_checksum  output  8  see Optional Feature.

Behaviour:
- States: IDLE, LOAD, RUN.
- Reset: state=IDLE, wr_ptr=0, prog_len=0, load_done=0, load_checksum=0. Memory contents are not cleared; prog_len gates reads.
- cpu_rst = (state != RUN). It is combinational from the state register, so the core sees reset in the same cycle the state leaves RUN.
- load_ready = (state==LOAD) && !load_start. A beat is accepted when load_valid && load_ready.
- Transitions from IDLE:
  - load_start -> LOAD; wr_ptr=0, prog_len=0.
  - Otherwise run_req -> RUN. This is legal with prog_len=0; the core then fetches FILL_INSTR only.
  - Other inputs are ignored.
- LOAD, accepted beat:
  - mem[wr_ptr] <= load_data.
  - prog_len <= wr_ptr+1.
  - wr_ptr increments.
  - If load_last, or wr_ptr==DEPTH-1, the load ends: next state RUN, and load_done is 1 for exactly the first RUN cycle.
  - Beats are never written past DEPTH-1 and there is no wrap-around.
- LOAD, other cases:
  - load_start restarts the load: wr_ptr=0, prog_len=0. Any beat presented in the same cycle is not accepted (ready is low).
  - run_req and halt_req are ignored.
- RUN:
  - load_start -> LOAD with restart as above; takes priority over halt_req.
  - halt_req -> IDLE; prog_len retained.
  - run_req is ignored.
- Read path: instruction = (state==RUN && pc < prog_len) ? mem[pc[ADDR_W-1:0]] : FILL_INSTR.
  - Compare the full 8-bit pc, so upper bits beyond ADDR_W make the address out-of-range.
  - Zero-cycle latency.
- Simultaneous load_start and halt_req in IDLE: load_start wins.
- RST asserted mid-load or mid-run: IDLE next cycle. Partially loaded bytes become unreadable because prog_len=0.

Optional Feature:
- Macro LOAD_CHECKSUM_EN.
- Defined:
  - load_checksum holds the 8-bit modulo-256 sum of all bytes accepted in the current load.
  - It clears on load_start and on reset, and holds its value after the load ends.
- Undefined: load_checksum is tied to 8'h00 and no adder is synthesized.
- The port is present in both builds.

Decomposition:
- Shared package holds:
  - state enum {IDLE, LOAD, RUN};
  - the default FILL_INSTR constant;
  - INSTR_W=8 and PC_W=8.
- One sub-module, instr_ram: DEPTH x 8, synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata). Range gating stays in program_loader.

Test Plan:
- Reset then idle: cpu_rst=1, load_ready=0, instruction=8'h00 for pc=8'h05, prog_len=0.
- Load 4 bytes 8'h41, 8'h86, 8'hC3, 8'h12 with load_last on 4th -> load_done pulses one cycle; cpu_rst=0; prog_len=4; pc=0..3 returns those bytes; pc=4 returns FILL_INSTR. With LOAD_CHECKSUM_EN, checksum = 8'h9C.
- Hold load_valid low for 3 cycles between beats 2 and 3 -> no extra writes; prog_len=4 after load_last; contents unchanged.
- ADDR_W=2, load 5 beats without load_last -> 4th beat ends load, load_ready=0 after; 5th byte never stored; prog_len=4; pc=8'h04 returns FILL_INSTR.
- In RUN, assert load_start with a valid beat in the same cycle -> beat not accepted; cpu_rst=1 same cycle; prog_len=0; instruction=FILL_INSTR.
- In RUN, halt_req -> IDLE, cpu_rst=1; then run_req -> RUN with the previous program readable. RST asserted mid-LOAD -> IDLE, prog_len=0.
